// File: rtl/i2c_target_regs_m.sv
// i2c_target_regs_m: I2C target that exposes a small byte-wide register bank.
//
// Oversamples SCL/SDA on bbc_ck8. It never drives SCL, and it drives SDA open-drain through sda_oe.
// Protocol: START, {DEV_ADDR, R/W}, then one of two forms.
//   Write: pointer byte, then data bytes, each written at the pointer, which then auto-increments.
//   Read:  data bytes from the current pointer, until the initiator NACKs.
// The pointer wraps modulo 2**PTR_W and is kept between transactions.
//
// Optional build macro: I2C_GLITCH_FILTER_EN adds a 3-sample agreement filter on both lines.
//
// Ports:
//   bbc_ck8    clock, all flops on the rising edge
//   reset      synchronous active-high reset
//   scl_in     raw SCL pad level (asynchronous)
//   sda_in     raw SDA pad level (asynchronous)
//   sda_oe     1 pulls SDA low, 0 releases it
//   reg_addr   current register pointer
//   reg_wdata  write data, valid while reg_wr_en=1
//   reg_wr_en  one-cycle write strobe
//   reg_rdata  read data for reg_addr (combinational from the parent)
//   reg_rd_en  one-cycle strobe when reg_rdata is captured
//   busy       1 from an address match until STOP
module i2c_target_regs_m #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned PTR_W    = 2
) (
  input  logic             bbc_ck8,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr_en,
  input  logic [7:0]       reg_rdata,
  output logic             reg_rd_en,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
  } state_e;

  // Input conditioning. Synchronizers reset to the idle-high bus level, so that no false
  // edge appears when reset is released.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge bbc_ck8) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  // The filtered level follows the line only when the current sample and the two before it agree.
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_comb begin
    scl_s = scl_filt_q;
    sda_s = sda_filt_q;
    if (&{scl_hist_q, scl_sync_q[1]}) scl_s = 1'b1;
    else if (~|{scl_hist_q, scl_sync_q[1]}) scl_s = 1'b0;
    if (&{sda_hist_q, sda_sync_q[1]}) sda_s = 1'b1;
    else if (~|{sda_hist_q, sda_sync_q[1]}) sda_s = 1'b0;
  end

  always_ff @(posedge bbc_ck8) begin
    if (reset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= scl_s;
      sda_filt_q <= sda_s;
    end
  end
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge bbc_ck8) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & sda_s & ~sda_prev_q;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;       // bits received so far in the current byte
  logic [6:0] tx_q;       // bits still to send after the one on the bus
  logic       rw_q;
  logic       ack_ph_q;   // 0: waiting for the fall that ends bit 8; 1: inside the ACK bit
  logic       mack_q;     // initiator's ACK bit, 0 = more bytes wanted
  logic [7:0] rx_next;

  assign rx_next = {rx_q, sda_s};

  always_ff @(posedge bbc_ck8) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      ack_ph_q  <= 1'b0;
      mack_q    <= 1'b1;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        ack_ph_q  <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              rx_q      <= rx_next[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_ph_q <= 1'b0;
                if (state_q == StAddr) begin
                  if (rx_next[7:1] == DEV_ADDR) begin
                    state_q <= StAddrAck;
                    rw_q    <= rx_next[0];
                    busy    <= 1'b1;
                  end else begin
                    state_q <= StIdle;
                  end
                end else if (state_q == StPtr) begin
                  reg_addr <= rx_next[PTR_W-1:0];
                  state_q  <= StPtrAck;
                end else begin
                  reg_wdata <= rx_next;
                  reg_wr_en <= 1'b1;
                  state_q   <= StWdataAck;
                end
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              if (!ack_ph_q) begin
                sda_oe   <= 1'b1;
                ack_ph_q <= 1'b1;
              end else begin
                ack_ph_q <= 1'b0;
                if (state_q == StAddrAck && rw_q) begin
                  reg_rd_en <= 1'b1;
                  tx_q      <= reg_rdata[6:0];
                  sda_oe    <= ~reg_rdata[7];
                  state_q   <= StRdata;
                end else begin
                  sda_oe  <= 1'b0;
                  state_q <= (state_q == StAddrAck) ? StPtr : StWdata;
                  if (state_q == StWdataAck) reg_addr <= reg_addr + 1'b1;
                end
              end
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_ph_q <= 1'b0;
                state_q  <= StRdataAck;
              end
            end else if (scl_fall) begin
              sda_oe <= ~tx_q[6];
              tx_q   <= {tx_q[5:0], 1'b0};
            end
          end
          StRdataAck: begin
            if (scl_fall && !ack_ph_q) begin
              sda_oe   <= 1'b0;
              ack_ph_q <= 1'b1;
            end else if (scl_rise && ack_ph_q) begin
              mack_q <= sda_s;
              // Advance the pointer on the ACK rise, so reg_rdata already shows the next
              // byte when it is captured on the following fall.
              if (!sda_s) reg_addr <= reg_addr + 1'b1;
            end else if (scl_fall && ack_ph_q) begin
              ack_ph_q <= 1'b0;
              if (!mack_q) begin
                reg_rd_en <= 1'b1;
                tx_q      <= reg_rdata[6:0];
                sda_oe    <= ~reg_rdata[7];
                state_q   <= StRdata;
              end else begin
                sda_oe  <= 1'b0;
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs_m.sv
`timescale 1ns/1ps
module tb_i2c_target_regs_m;

  localparam int unsigned Q = 16;  // clock cycles per SCL phase
  localparam logic [7:0] AddrW = 8'hA0;
  localparam logic [7:0] AddrR = 8'hA1;

  logic bbc_ck8 = 1'b0;
  always #5 bbc_ck8 = ~bbc_ck8;

  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;  // open-drain wired-AND

  // Parent register file, written only by DUT strobes.
  logic [7:0] bank [4] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
  assign reg_rdata = bank[reg_addr];

  i2c_target_regs_m #(
    .DEV_ADDR(7'h50),
    .PTR_W   (2)
  ) dut (
    .bbc_ck8  (bbc_ck8),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rdata(reg_rdata),
    .reg_rd_en(reg_rd_en),
    .busy     (busy)
  );

  // Strobe monitor.
  logic [9:0]  wr_log [$];
  logic [1:0]  rd_log [$];
  int unsigned oe_cnt = 0;
  int unsigned both_cnt = 0;
  always @(negedge bbc_ck8) begin
    if (reg_wr_en) begin
      wr_log.push_back({reg_addr, reg_wdata});
      bank[reg_addr] = reg_wdata;
    end
    if (reg_rd_en) rd_log.push_back(reg_addr);
    if (reg_wr_en && reg_rd_en) both_cnt++;
    if (sda_oe) oe_cnt++;
  end

  // Reference model: register contents and pointer as an initiator expects them.
  logic [7:0] model_bank [4];
  logic [1:0] model_ptr;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge bbc_ck8);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    sda_m = b; tick(Q);
    scl_m = 1'b1;
    if (glitch) begin
      tick(6); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(Q - 8);
    end else begin
      tick(Q);
    end
    scl_m = 1'b0; tick(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q / 2);
    b = sda_in;
    tick(Q / 2);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 0; i < 8; i++) write_bit(b[7-i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack, 1'b0);
  endtask

  task automatic do_write(input logic [1:0] ptr, input int n, input logic [23:0] data);
    logic       ack;
    int         base;
    logic [9:0] exp [3];
    logic [9:0] got;
    logic [7:0] byt;
    base = wr_log.size();
    i2c_start();
    send_byte(AddrW, -1, ack);
    check_eq("wr_addr_ack", ack, 0);
    check_eq("wr_busy", busy, 1);
    send_byte({6'($urandom), ptr}, -1, ack);  // upper pointer bits are don't-care
    check_eq("wr_ptr_ack", ack, 0);
    model_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      byt = data[23-8*i -: 8];
      send_byte(byt, -1, ack);
      check_eq("wr_data_ack", ack, 0);
      exp[i] = {model_ptr, byt};
      model_bank[model_ptr] = byt;
      model_ptr = model_ptr + 2'd1;
    end
    i2c_stop();
    check_eq("wr_busy_stop", busy, 0);
    check_eq("wr_count", wr_log.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < wr_log.size()) ? wr_log[base+i] : 10'h3FF;
      check_eq("wr_addr_data", got, exp[i]);
    end
  endtask

  task automatic do_read(input bit set_ptr, input logic [1:0] ptr, input int n);
    logic       ack;
    logic [7:0] d;
    int         base;
    logic [1:0] exp_addr [3];
    logic [1:0] got;
    base = rd_log.size();
    i2c_start();
    if (set_ptr) begin
      send_byte(AddrW, -1, ack);
      check_eq("rd_waddr_ack", ack, 0);
      send_byte({6'($urandom), ptr}, -1, ack);
      check_eq("rd_ptr_ack", ack, 0);
      model_ptr = ptr;
      i2c_start();
    end
    send_byte(AddrR, -1, ack);
    check_eq("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_addr[i] = model_ptr;
      recv_byte(d, i == n - 1);
      check_eq("rd_data", d, model_bank[model_ptr]);
      if (i != n - 1) model_ptr = model_ptr + 2'd1;
    end
    check_eq("rd_release", sda_oe, 0);
    i2c_stop();
    check_eq("rd_busy_stop", busy, 0);
    check_eq("rd_count", rd_log.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < rd_log.size()) ? rd_log[base+i] : 2'bxx;
      check_eq("rd_strobe_addr", got, exp_addr[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ack;
    int         wbase, rbase, obase;
    logic [7:0] gbyte, gexp;
    logic [8:0] seq;
    logic [23:0] rdat;

    model_bank = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
    model_ptr  = 2'd0;

    tick(5);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_wdata", reg_wdata, 0);
    check_eq("rst_wr_en", reg_wr_en, 0);
    check_eq("rst_rd_en", reg_rd_en, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    tick(Q);

    // Pointer then single write.
    do_write(2'd1, 1, {8'h5A, 16'h0});
    // Auto-increment write with pointer wrap 3 -> 0.
    do_write(2'd3, 2, {8'h11, 8'h22, 8'h00});
    // Pointer then read through repeated START.
    do_write(2'd2, 2, {8'hC3, 8'h3C, 8'h00});
    do_read(1'b1, 2'd2, 2);

    // Address mismatch: no ACK, no strobes, SDA never pulled.
    wbase = wr_log.size(); rbase = rd_log.size(); obase = oe_cnt;
    i2c_start();
    send_byte(8'hB0, -1, ack);
    check_eq("mm_addr_nack", ack, 1);
    check_eq("mm_busy", busy, 0);
    send_byte(8'h55, -1, ack);
    check_eq("mm_data_nack", ack, 1);
    i2c_stop();
    check_eq("mm_oe_cycles", oe_cnt - obase, 0);
    check_eq("mm_wr_count", wr_log.size() - wbase, 0);
    check_eq("mm_rd_count", rd_log.size() - rbase, 0);
    check_eq("mm_busy_stop", busy, 0);

    // Abort mid-byte: partial data byte must not write.
    wbase = wr_log.size();
    i2c_start();
    send_byte(AddrW, -1, ack);
    send_byte(8'h00, -1, ack);
    model_ptr = 2'd0;
    for (int i = 0; i < 4; i++) write_bit(i[0], 1'b0);
    i2c_stop();
    check_eq("abort_wr_count", wr_log.size() - wbase, 0);

    // Reset while the target is driving a 0 data bit.
    do_write(2'd0, 1, {8'h35, 16'h0});
    i2c_start();
    send_byte(AddrW, -1, ack);
    send_byte(8'h00, -1, ack);
    i2c_start();
    send_byte(AddrR, -1, ack);
    check_eq("rst_rd_ack", ack, 0);
    check_eq("rst_pre_oe", sda_oe, {31'd0, ~model_bank[0][7]});
    reset = 1'b1;
    tick(1);
    check_eq("rst_mid_sda_oe", sda_oe, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_reg_addr", reg_addr, 0);
    check_eq("rst_mid_wr_en", reg_wr_en, 0);
    check_eq("rst_mid_rd_en", reg_rd_en, 0);
    check_eq("rst_mid_wdata", reg_wdata, 0);
    tick(2);
    reset = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(Q);
    model_ptr = 2'd0;

    // Randomized transactions against the model.
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        rdat = $urandom;
        do_write(2'($urandom_range(0, 3)), $urandom_range(1, 3), rdat);
      end else begin
        do_read(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(1, 3));
      end
    end

    // SCL glitch during a data byte. Without the filter, the glitch counts as an extra
    // rising edge, so the bit on the bus at that moment is sampled twice.
    gbyte = 8'h5A;
`ifdef I2C_GLITCH_FILTER_EN
    gexp = gbyte;
`else
    seq  = {gbyte[7:4], gbyte[4], gbyte[3:0]};
    gexp = seq[8:1];
`endif
    wbase = wr_log.size();
    i2c_start();
    send_byte(AddrW, -1, ack);
    send_byte(8'h01, -1, ack);
    send_byte(gbyte, 3, ack);
    i2c_stop();
    check_eq("glitch_wr_count", wr_log.size() - wbase, 1);
    check_eq("glitch_wr", (wbase < wr_log.size()) ? wr_log[wbase] : 10'h3FF, {2'd1, gexp});
    model_bank[1] = gexp;
    model_ptr = 2'd2;
    do_read(1'b1, 2'd1, 1);

    check_eq("strobe_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
